// File: rtl/lampfpu_sqrt_issue_pkg.sv
// Shared constants and types for the bfloat16 square-root issue/return controller.
package lampfpu_sqrt_issue_pkg;

    localparam int          LAMP_FLOAT_E_BIAS = 127;
    localparam logic [15:0] LAMP_QNAN         = 16'h7FC0;
    localparam logic [15:0] LAMP_PINF         = 16'h7F80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } sqrt_state_e;

    // Exception flags in output order {nv, dz, to}
    typedef struct packed {
        logic nv;
        logic dz;
        logic to;
    } sqrt_flags_t;

endpackage

// File: rtl/lampfpu_sqrt_issue_if.sv
// Operand/result handshake bus between the FPU issue logic (master) and the
// square-root issue controller (slave).
interface lampfpu_sqrt_issue_if;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [15:0] op_i;
    logic        inv_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_o;
    logic [2:0]  flags_o;

    modport master (
        output op_valid_i, op_i, inv_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_o, flags_o
    );

    modport slave (
        input  op_valid_i, op_i, inv_i, res_ready_i,
        output op_ready_o, res_valid_o, res_o, flags_o
    );
endinterface

// File: rtl/lampfpu_sqrt_issue_classify.sv
// Combinational operand classifier: resolves NaN/zero/negative/infinity
// operands to their final result, otherwise produces the unbiased exponent
// and hidden-bit mantissa for the square-root core.
module lampfpu_sqrt_issue_classify
    import lampfpu_sqrt_issue_pkg::*;
(
    input  logic              [15:0] op,
    input  logic                     inv,
    output logic                     special,
    output logic              [15:0] spec_res,
    output sqrt_flags_t              spec_flags,
    output logic signed       [7:0]  exp_unb,
    output logic              [7:0]  mant
);
    logic       sgn;
    logic [7:0] e;
    logic [6:0] f;

    assign sgn = op[15];
    assign e   = op[14:7];
    assign f   = op[6:0];

    // Modulo-256 subtraction gives the right two's complement for normal exponents
    assign exp_unb = $signed(e - 8'(LAMP_FLOAT_E_BIAS));
    assign mant    = {1'b1, f};

    // Special-operand resolution in priority order: NaN, zero/subnormal, negative, +inf
    always_comb begin
        special    = 1'b1;
        spec_res   = 16'h0000;
        spec_flags = '0;
        if (e == 8'hFF && f != 7'd0) begin
            spec_res      = LAMP_QNAN;
            spec_flags.nv = ~f[6];
        end else if (e == 8'h00) begin
            // Subnormals flush to zero; the sign survives into the result
            if (inv) begin
                spec_res      = {sgn, LAMP_PINF[14:0]};
                spec_flags.dz = 1'b1;
            end else begin
                spec_res = {sgn, 15'd0};
            end
        end else if (sgn) begin
            spec_res      = LAMP_QNAN;
            spec_flags.nv = 1'b1;
        end else if (e == 8'hFF) begin
            spec_res = inv ? 16'h0000 : LAMP_PINF;
        end else begin
            special = 1'b0;
        end
    end

endmodule

// File: rtl/lampfpu_sqrt_issue.sv
// Issue/return controller wrapping the LAMP FPU square-root stage.
// Optional hang detection in WAIT is enabled by defining
// LAMP_SQRT_ISSUE_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module lampfpu_sqrt_issue
    import lampfpu_sqrt_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    lampfpu_sqrt_issue_if.slave bus,
    output logic                sq_do_sqrt_o,
    output logic                sq_do_inv_sqrt_o,
    output logic                sq_s_o,
    output logic signed [7:0]   sq_e_o,
    output logic        [7:0]   sq_m_o,
    input  logic                sq_valid_i,
    input  logic                sq_s_i,
    input  logic signed [7:0]   sq_e_i,
    input  logic        [7:0]   sq_m_i
);
    sqrt_state_e        state;
    logic               op_ready_q;
    logic               res_valid_q;
    logic        [15:0] res_q;
    sqrt_flags_t        flags_q;
    logic               do_sqrt_q;
    logic               do_inv_q;
    logic               sq_s_q;
    logic signed [7:0]  sq_e_q;
    logic        [7:0]  sq_m_q;
    logic        [15:0] op_q;
    logic               inv_q;

    logic               cls_special;
    logic        [15:0] cls_res;
    sqrt_flags_t        cls_flags;
    logic signed [7:0]  cls_exp;
    logic        [7:0]  cls_mant;

`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    // Without hang detection the limit has no consumer
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // The core result is always non-negative; its sign output carries no information
    logic unused_sq_s;
    assign unused_sq_s = sq_s_i;

    // Re-bias the core exponent and saturate to +inf / +0 at the range limits
    function automatic logic [15:0] pack_result(input logic signed [7:0] e, input logic [7:0] m);
        logic signed [8:0] b;
        b = $signed({e[7], e}) + 9'(LAMP_FLOAT_E_BIAS);
        if (m == 8'd0)
            return 16'h0000;
        else if (b >= 9'sd255)
            return LAMP_PINF;
        else if (b <= 9'sd0)
            return 16'h0000;
        else
            return {1'b0, b[7:0], m[6:0]};
    endfunction

    lampfpu_sqrt_issue_classify u_classify (
        .op         (op_q),
        .inv        (inv_q),
        .special    (cls_special),
        .spec_res   (cls_res),
        .spec_flags (cls_flags),
        .exp_unb    (cls_exp),
        .mant       (cls_mant)
    );

    // Operand capture on acceptance; held for the whole operation
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.op_valid_i && op_ready_q) begin
            op_q  <= bus.op_i;
            inv_q <= bus.inv_i;
        end
    end

    // Issue/return FSM with registered handshake, result and core-launch outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_q       <= 16'h0000;
            flags_q     <= '0;
            do_sqrt_q   <= 1'b0;
            do_inv_q    <= 1'b0;
            sq_s_q      <= 1'b0;
            sq_e_q      <= 8'sd0;
            sq_m_q      <= 8'd0;
`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            do_sqrt_q <= 1'b0;
            do_inv_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid_i && op_ready_q) begin
                        op_ready_q <= 1'b0;
                        flags_q    <= '0;
                        state      <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (cls_special) begin
                        res_q       <= cls_res;
                        flags_q     <= cls_flags;
                        res_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        sq_s_q    <= 1'b0;
                        sq_e_q    <= cls_exp;
                        sq_m_q    <= cls_mant;
                        // Raised here so the pulse is visible during LAUNCH
                        do_sqrt_q <= ~inv_q;
                        do_inv_q  <= inv_q;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A core answer on the final counted cycle still takes priority
                    if (sq_valid_i) begin
                        res_q       <= pack_result(sq_e_i, sq_m_i);
                        res_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_q       <= LAMP_QNAN;
                        flags_q.to  <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready_o  = op_ready_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_o       = res_q;
    assign bus.flags_o     = flags_q;

    assign sq_do_sqrt_o     = do_sqrt_q;
    assign sq_do_inv_sqrt_o = do_inv_q;
    assign sq_s_o           = sq_s_q;
    assign sq_e_o           = sq_e_q;
    assign sq_m_o           = sq_m_q;

endmodule

// File: tb/tb_lampfpu_sqrt_issue.sv
// Directed testbench for lampfpu_sqrt_issue with an operation-level reference model.
module tb_lampfpu_sqrt_issue;

`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 32;
`endif

    logic              clk;
    logic              rst;
    logic              sq_do_sqrt_o;
    logic              sq_do_inv_sqrt_o;
    logic              sq_s_o;
    logic signed [7:0] sq_e_o;
    logic        [7:0] sq_m_o;
    logic              sq_valid_i;
    logic              sq_s_i;
    logic signed [7:0] sq_e_i;
    logic        [7:0] sq_m_i;

    lampfpu_sqrt_issue_if ifc ();

    lampfpu_sqrt_issue #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (ifc.slave),
        .sq_do_sqrt_o     (sq_do_sqrt_o),
        .sq_do_inv_sqrt_o (sq_do_inv_sqrt_o),
        .sq_s_o           (sq_s_o),
        .sq_e_o           (sq_e_o),
        .sq_m_o           (sq_m_o),
        .sq_valid_i       (sq_valid_i),
        .sq_s_i           (sq_s_i),
        .sq_e_i           (sq_e_i),
        .sq_m_i           (sq_m_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          n_sqrt   = 0;
    int          n_inv    = 0;
    bit          exp_pending = 0;
    logic [15:0] exp_res  = 16'h0;
    logic [2:0]  exp_flags = 3'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: what the controller must answer for one operand
    function automatic void model_op(input logic [15:0] op, input logic inv,
                                     output bit sp, output logic [15:0] res,
                                     output logic [2:0] fl, output int ue,
                                     output logic [7:0] m);
        int ex, fr;
        bit neg;
        ex  = int'(op[14:7]);
        fr  = int'(op[6:0]);
        neg = op[15];
        sp  = 1;
        fl  = 3'b000;
        res = 16'h0000;
        ue  = ex - 127;
        m   = 8'(128 + fr);
        if (ex == 255 && fr != 0) begin
            res   = 16'h7FC0;
            fl[2] = (fr < 64);
        end else if (ex == 0) begin
            if (inv) begin
                res   = neg ? 16'hFF80 : 16'h7F80;
                fl[1] = 1'b1;
            end else begin
                res = neg ? 16'h8000 : 16'h0000;
            end
        end else if (neg) begin
            res   = 16'h7FC0;
            fl[2] = 1'b1;
        end else if (ex == 255) begin
            res = inv ? 16'h0000 : 16'h7F80;
        end else begin
            sp = 0;
        end
    endfunction

    function automatic logic [15:0] model_pack(input int ce, input int cm);
        int b;
        if (cm == 0) return 16'h0000;
        b = ce + 127;
        if (b >= 255) return 16'h7F80;
        if (b <= 0) return 16'h0000;
        return 16'((b << 7) | (cm & 127));
    endfunction

    // Compare process: any visible result must be the one the model expects
    always @(negedge clk) begin
        if (sq_do_sqrt_o) n_sqrt++;
        if (sq_do_inv_sqrt_o) n_inv++;
        if (ifc.res_valid_o) begin
            checks++;
            if (!exp_pending || ifc.res_o !== exp_res || ifc.flags_o !== exp_flags) begin
                failures++;
                $display("FAIL res_cmp: got res=0x%0h flags=%b pending=%0d, expected res=0x%0h flags=%b",
                         ifc.res_o, ifc.flags_o, exp_pending, exp_res, exp_flags);
            end
        end
    end

    // One complete operation; delay<0 means the core never answers
    task automatic do_op(input logic [15:0] op, input logic inv, input int delay,
                         input int ce, input int cm, input int bp);
        bit          sp;
        logic [15:0] mres;
        logic [2:0]  mfl;
        int          ue;
        logic [7:0]  mm;
        int          n, n0s, n0i;
        model_op(op, inv, sp, mres, mfl, ue, mm);
        n = 0;
        while (!ifc.op_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("op_ready_idle", ifc.op_ready_o, 1);
        n0s = n_sqrt;
        n0i = n_inv;
        if (sp) begin exp_res = mres; exp_flags = mfl; end
        else if (delay < 0) begin exp_res = 16'h7FC0; exp_flags = 3'b001; end
        else begin exp_res = model_pack(ce, cm); exp_flags = 3'b000; end
        exp_pending = 1;
        ifc.op_valid_i = 1'b1;
        ifc.op_i       = op;
        ifc.inv_i      = inv;
        @(posedge clk); #1;
        ifc.op_valid_i = 1'b0;
        chk("op_ready_busy", ifc.op_ready_o, 0);
        chk("valid_cyc1", ifc.res_valid_o, 0);
        @(posedge clk); #1;
        if (sp) begin
            chk("spec_valid_cyc2", ifc.res_valid_o, 1);
        end else begin
            chk("launch_sqrt", sq_do_sqrt_o, !inv);
            chk("launch_inv", sq_do_inv_sqrt_o, inv);
            chk("sq_e", {24'b0, sq_e_o}, ue & 255);
            chk("sq_m", sq_m_o, mm);
            chk("sq_s", sq_s_o, 0);
            @(posedge clk); #1;
            if (delay >= 0) begin
                repeat (delay) begin @(posedge clk); #1; end
                chk("no_valid_before_core", ifc.res_valid_o, 0);
                chk("sq_e_held", {24'b0, sq_e_o}, ue & 255);
                sq_valid_i = 1'b1;
                sq_e_i     = 8'(ce);
                sq_m_i     = 8'(cm);
                @(posedge clk); #1;
                sq_valid_i = 1'b0;
                chk("valid_after_core", ifc.res_valid_o, 1);
            end else begin
                n = 0;
                while (!ifc.res_valid_o && n < 60) begin @(posedge clk); #1; n++; end
                chk("timeout_cycles", n, TO_CYC);
            end
        end
        chk("n_sqrt_pulses", n_sqrt - n0s, (!sp && !inv) ? 1 : 0);
        chk("n_inv_pulses", n_inv - n0i, (!sp && inv) ? 1 : 0);
        repeat (bp) begin
            ifc.op_valid_i = 1'b1;
            ifc.op_i       = 16'h4080;
            @(posedge clk); #1;
            chk("bp_valid", ifc.res_valid_o, 1);
            chk("bp_op_ready", ifc.op_ready_o, 0);
            chk("bp_res", ifc.res_o, exp_res);
            chk("bp_flags", ifc.flags_o, exp_flags);
        end
        ifc.op_valid_i  = 1'b0;
        ifc.res_ready_i = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready_i = 1'b0;
        exp_pending     = 0;
        chk("release_valid", ifc.res_valid_o, 0);
        chk("release_ready", ifc.op_ready_o, 1);
        chk("flags_persist", ifc.flags_o, exp_flags);
    endtask

    bit          p_sp;
    logic [15:0] p_res;
    logic [2:0]  p_fl;
    int          p_ue;
    logic [7:0]  p_m;

    initial begin
        rst             = 1'b0;
        ifc.op_valid_i  = 1'b0;
        ifc.op_i        = 16'h0;
        ifc.inv_i       = 1'b0;
        ifc.res_ready_i = 1'b0;
        sq_valid_i      = 1'b0;
        sq_s_i          = 1'b0;
        sq_e_i          = 8'sd0;
        sq_m_i          = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", ifc.op_ready_o, 1);
        chk("rst_res_valid", ifc.res_valid_o, 0);
        chk("rst_res", ifc.res_o, 0);
        chk("rst_flags", ifc.flags_o, 0);
        chk("rst_launch", {sq_do_sqrt_o, sq_do_inv_sqrt_o}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Model pins against hand-computed values
        model_op(16'h4080, 1'b0, p_sp, p_res, p_fl, p_ue, p_m);
        chk("pin_4_special", p_sp, 0);
        chk("pin_4_e", p_ue, 2);
        chk("pin_4_m", p_m, 8'h80);
        chk("pin_pack_sqrt4", model_pack(1, 8'h80), 16'h4000);
        chk("pin_pack_inv4", model_pack(-1, 8'h80), 16'h3F00);
        chk("pin_pack_max", model_pack(127, 8'hC5), 16'h7F45);
        model_op(16'hC080, 1'b0, p_sp, p_res, p_fl, p_ue, p_m);
        chk("pin_neg_res", p_res, 16'h7FC0);
        chk("pin_neg_fl", p_fl, 3'b100);
        model_op(16'h0000, 1'b1, p_sp, p_res, p_fl, p_ue, p_m);
        chk("pin_zero_inv_res", p_res, 16'h7F80);
        chk("pin_zero_inv_fl", p_fl, 3'b010);

        // Normal operands through the core
        do_op(16'h4080, 1'b0, 0, 1, 8'h80, 0);
        do_op(16'h4080, 1'b1, 2, -1, 8'h80, 0);
        do_op(16'h3F80, 1'b1, 3, 0, 8'h80, 5);
        do_op(16'h0080, 1'b0, 1, -127, 8'h90, 0);
        do_op(16'h7F7F, 1'b0, 0, 127, 8'hC5, 0);
        do_op(16'h4100, 1'b0, 0, 1, 8'h00, 0);
        do_op(16'h4100, 1'b1, 0, -128, 8'hB5, 0);

        // Special operands resolved without the core
        do_op(16'hC080, 1'b0, 0, 0, 0, 0);
        do_op(16'h0000, 1'b1, 0, 0, 0, 0);
        do_op(16'h7F81, 1'b0, 0, 0, 0, 5);
        do_op(16'h7FC1, 1'b0, 0, 0, 0, 0);
        do_op(16'h8000, 1'b1, 0, 0, 0, 0);
        do_op(16'h8000, 1'b0, 0, 0, 0, 0);
        do_op(16'h0005, 1'b0, 0, 0, 0, 0);
        do_op(16'h7F80, 1'b1, 0, 0, 0, 0);
        do_op(16'h7F80, 1'b0, 0, 0, 0, 0);
        do_op(16'hFF80, 1'b0, 0, 0, 0, 0);

        // Asynchronous reset in WAIT discards the in-flight operation
        exp_pending    = 0;
        ifc.op_valid_i = 1'b1;
        ifc.op_i       = 16'h4080;
        ifc.inv_i      = 1'b0;
        @(posedge clk); #1;
        ifc.op_valid_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_op_ready", ifc.op_ready_o, 1);
        chk("arst_res_valid", ifc.res_valid_o, 0);
        chk("arst_res", ifc.res_o, 0);
        chk("arst_flags", ifc.flags_o, 0);
        chk("arst_sq_e", {24'b0, sq_e_o}, 0);
        chk("arst_sq_m", sq_m_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        sq_valid_i = 1'b1;
        sq_e_i     = 8'sd1;
        sq_m_i     = 8'h80;
        @(posedge clk); #1;
        sq_valid_i = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("late_core_ignored", ifc.res_valid_o, 0);
            chk("late_core_ready", ifc.op_ready_o, 1);
        end

`ifdef LAMP_SQRT_ISSUE_TIMEOUT_EN
        // Core never answers: hang detection returns qNaN with the timeout flag
        do_op(16'h4080, 1'b0, -1, 0, 0, 0);
        // Core answers on the last counted cycle: the real result wins
        do_op(16'h4080, 1'b0, TO_CYC - 1, 1, 8'h80, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lampfpu_sqrt_issue.md
# lampFPU_sqrt_issue

Issue/return controller that wraps the floating-point square-root stage of the LAMP FPU. Accepts a packed bfloat16 operand with a valid/ready handshake, classifies it, resolves special operands locally, and for normal operands launches the SQRT stage with an unbiased exponent and hidden-bit mantissa. It captures the SQRT stage's normalized result, re-biases and packs it, and returns it with a valid/ready handshake. It sits between the FPU issue logic and the SQRT stage, driving the stage's inputs and consuming its outputs.

## Interface
- TIMEOUT_CYCLES, 32: maximum WAIT cycles before the core is declared hung; only used with the timeout macro.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- op_valid_i  in  1  operand valid
- op_ready_o  out  1  operand ready; reset 1
- op_i  in  16  bfloat16 operand {s, e[7:0], f[6:0]}
- inv_i  in  1  1 = 1/sqrt, 0 = sqrt; sampled with op_i
- res_valid_o  out  1  result valid; reset 0
- res_ready_i  in  1  result consumer ready
- res_o  out  16  packed bfloat16 result; reset 0
- flags_o  out  3  {nv, dz, to}; reset 0
- sq_do_sqrt_o / sq_do_inv_sqrt_o  out  1  one-cycle launch pulses; reset 0
- sq_s_o  out  1; sq_e_o  out  8 signed unbiased; sq_m_o  out  8 {1,f}; reset 0
- sq_valid_i  in  1; sq_s_i  in  1; sq_e_i  in  8 signed; sq_m_i  in  8  SQRT stage result

## Operation
- FSM: IDLE, CLASSIFY, LAUNCH, WAIT, RESP. Reset → IDLE.
- IDLE: op_ready_o=1. On op_valid_i&&op_ready_o, capture op_i and inv_i, then go to CLASSIFY. op_ready_o=0 in all other states.
- CLASSIFY (1 cycle), in priority order:
  - NaN (e=FF, f≠0) → res 0x7FC0; nv=1 if signaling (f[6]=0).
  - zero or subnormal (e=0): subnormals are flushed to zero, sign kept. sqrt → ±0. inv → ±inf (0x7F80 / 0xFF80), dz=1.
  - negative nonzero → 0x7FC0, nv=1.
  - +inf: sqrt → 0x7F80; inv → 0x0000.
  - Special cases go directly to RESP without launching the core.
  - Normal: register sq_e_o = e−127 (range −126..127), sq_m_o = {1,f}, sq_s_o = 0, then go to LAUNCH.
- LAUNCH: pulse sq_do_sqrt_o or sq_do_inv_sqrt_o for exactly one cycle; clear the timeout counter; go to WAIT.
- sq_s_o/sq_e_o/sq_m_o are held stable from CLASSIFY until leaving WAIT.
- WAIT: on the first cycle with sq_valid_i=1, pack the result and go to RESP.
  - sq_m_i=0 → +0.
  - Otherwise b = sq_e_i + 127, computed 9-bit signed. b≥255 → +inf; b≤0 → +0; else res = {0, b[7:0], sq_m_i[6:0]}.
- sq_valid_i outside WAIT is ignored.
- RESP: res_valid_o=1; res_o and flags_o are held stable. On res_ready_i, go to IDLE the next cycle. flags_o persists until the next acceptance, then clears.
- Async reset at any point returns to IDLE with all reset values; any in-flight core result is discarded.

## Timing
- Acceptance edge = cycle 0. CLASSIFY occupies cycle 1.
- Special case: res_valid_o is high from cycle 2.
- Normal: launch pulse in cycle 2; res_valid_o is high the cycle after sq_valid_i is sampled in WAIT.
- Minimum occupancy: RESP plus one cycle back in IDLE before the next op_ready_o. No back-to-back overlap; one operation in flight.
- All outputs are registered.

## Configuration
- LAMP_SQRT_ISSUE_TIMEOUT_EN defined:
  - WAIT counts cycles. If TIMEOUT_CYCLES cycles elapse with no sq_valid_i, res = 0x7FC0, to=1, go to RESP.
  - If sq_valid_i and the final count coincide, the valid result wins.
- Undefined: no counter; WAIT holds indefinitely; flags_o[0] is tied 0.

## Structure
- lampFPU_pkg: LAMP_FLOAT_E_BIAS (127), LAMP_QNAN (0x7FC0), LAMP_PINF (0x7F80), FSM state enum typedef, packed flag struct {nv, dz, to}.
- One combinational sub-module, lampFPU_sqrt_classify: takes op/inv; returns special flag, special result, flags, unbiased exponent, and mantissa.

## Test plan
- 4.0 (0x4080), sqrt:
  - Expect sq_e_o=2, sq_m_o=0x80 and one sq_do_sqrt_o pulse.
  - Model core returns e=1, m=0x80 → res_o=0x4000, flags 0.
- 4.0, inv:
  - Expect sq_do_inv_sqrt_o pulse.
  - Model returns e=−1, m=0x80 → res_o=0x3F00.
- Specials, core never pulsed:
  - −4.0 (0xC080) sqrt → 0x7FC0, nv=1.
  - +0 inv → 0x7F80, dz=1.
  - 0x7F81 → 0x7FC0, nv=1.
  - Each with res_valid_o high in cycle 2.
- Backpressure: hold res_ready_i low 5 cycles in RESP.
  - res_o/flags_o remain stable; op_ready_o stays 0 and op_valid_i is ignored.
  - Release → IDLE next cycle.
- Timeout (macro on, TIMEOUT_CYCLES=8): core never answers → after 8 WAIT cycles res_o=0x7FC0, flags_o=3'b001.
- Reset asserted mid-WAIT:
  - All outputs return to reset values immediately and op_ready_o=1.
  - A late sq_valid_i is ignored and no result is emitted.
